// File: rtl/arcade_input.sv
// Player-input front end for arcade cores: decodes PS/2 keys for two players,
// merges them with two HPS joysticks, and applies autofire and coin stretching.
// Every output comes straight from a register in the clk domain.
module arcade_input #(
  parameter int NUM_BUTTONS   = 2,
  parameter int AUTOFIRE_HALF = 1600000,
  parameter int COIN_PULSE    = 9600000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [10:0]            ps2_key,
  input  logic [5+NUM_BUTTONS:0] joystick_0,
  input  logic [5+NUM_BUTTONS:0] joystick_1,
  input  logic                   share,
  input  logic [NUM_BUTTONS-1:0] autofire_en,
  output logic [3:0]             joy_1,
  output logic [3:0]             joy_2,
  output logic [NUM_BUTTONS-1:0] buttons_1,
  output logic [NUM_BUTTONS-1:0] buttons_2,
  output logic                   start_1,
  output logic                   start_2,
  output logic                   coin_1,
  output logic                   coin_2
);

  // Internal key/raw vectors use the joystick bit layout.
  localparam int W  = 6 + NUM_BUTTONS;
  localparam int FB = 4;                  // first fire bit
  localparam int SB = 4 + NUM_BUTTONS;    // start bit
  localparam int KB = 5 + NUM_BUTTONS;    // coin bit
  localparam int CW = $clog2(AUTOFIRE_HALF + 1);
  localparam int PW = $clog2(COIN_PULSE + 1);
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic          act;    // autofire was active (enabled and held) last cycle
    logic          btn;    // registered button output
    logic          phase;
    logic [CW-1:0] cnt;
  } af_t;

  typedef enum logic [1:0] {
    C_IDLE  = 2'd0,
    C_PULSE = 2'd1,
    C_WAIT  = 2'd2
  } coin_state_t;

  function automatic logic [W-1:0] bit_mask(input int pos);
    return ONE << pos;
  endfunction

  // Fire keys beyond the configured button count decode to nothing.
  function automatic logic [W-1:0] fire_mask(input int idx);
    logic [W-1:0] m;
    if (idx < NUM_BUTTONS) m = ONE << (FB + idx);
    else                   m = '0;
    return m;
  endfunction

  function automatic logic [W-1:0] p1_map(input logic [7:0] code);
    logic [W-1:0] m;
    case (code)
      8'h75:   m = bit_mask(3);
      8'h72:   m = bit_mask(2);
      8'h6B:   m = bit_mask(1);
      8'h74:   m = bit_mask(0);
      8'h14:   m = fire_mask(0);
      8'h11:   m = fire_mask(1);
      8'h29:   m = fire_mask(2);
      8'h16:   m = bit_mask(SB);
      8'h2E:   m = bit_mask(KB);
      default: m = '0;
    endcase
    return m;
  endfunction

  function automatic logic [W-1:0] p2_map(input logic [7:0] code);
    logic [W-1:0] m;
    case (code)
      8'h2D:   m = bit_mask(3);
      8'h2B:   m = bit_mask(2);
      8'h23:   m = bit_mask(1);
      8'h34:   m = bit_mask(0);
      8'h1C:   m = fire_mask(0);
      8'h1B:   m = fire_mask(1);
      8'h15:   m = fire_mask(2);
      8'h1E:   m = bit_mask(SB);
      8'h36:   m = bit_mask(KB);
      default: m = '0;
    endcase
    return m;
  endfunction

  // One autofire step; a hold that starts (or is newly enabled) begins high.
  function automatic af_t af_next(input logic raw_b, input logic en, input af_t cur);
    af_t           n;
    logic          ph;
    logic [CW-1:0] ct;
    n     = '0;
    n.act = raw_b & en;
    if (raw_b & en) begin
      ph    = cur.act ? cur.phase : 1'b1;
      ct    = cur.act ? cur.cnt : '0;
      n.btn = ph;
      if (ct == CW'(AUTOFIRE_HALF - 1)) begin
        n.phase = ~ph;
        n.cnt   = '0;
      end else begin
        n.phase = ph;
        n.cnt   = ct + CW'(1);
      end
    end else begin
      n.btn = raw_b & ~en;
    end
    return n;
  endfunction

  logic             toggle_r;
  logic [W-1:0]     keys1_r, keys2_r;
  logic [W-1:0]     mask1, mask2;
  logic             key_event;
  logic [1:0][W-1:0] raw;
  af_t              af_r [2][NUM_BUTTONS];
  coin_state_t      coin_st_r [2], coin_st_nxt [2];
  logic [PW-1:0]    coin_cnt_r [2], coin_cnt_nxt [2];
  logic             coin_prev_r [2];
  logic             coin_out_r [2], coin_out_nxt [2];
  logic             unused_ext;

  assign unused_ext = ps2_key[8];

  // Key event detection and scan-code lookup for both players.
  always_comb begin
    key_event = ps2_key[10] != toggle_r;
    mask1     = p1_map(ps2_key[7:0]);
    mask2     = p2_map(ps2_key[7:0]);
  end

  // Key state registers; reset reloads the toggle so no stale event fires.
  always_ff @(posedge clk) begin
    if (reset) begin
      toggle_r <= ps2_key[10];
      keys1_r  <= '0;
      keys2_r  <= '0;
    end else if (key_event) begin
      toggle_r <= ps2_key[10];
      keys1_r  <= ps2_key[9] ? (keys1_r | mask1) : (keys1_r & ~mask1);
      keys2_r  <= ps2_key[9] ? (keys2_r | mask2) : (keys2_r & ~mask2);
    end
  end

  // Merge keyboard and joystick sources, shared or per player.
  always_comb begin
    if (share) begin
      raw[0] = keys1_r | keys2_r | joystick_0 | joystick_1;
      raw[1] = keys1_r | keys2_r | joystick_0 | joystick_1;
    end else begin
      raw[0] = keys1_r | joystick_0;
      raw[1] = keys2_r | joystick_1;
    end
  end

  // Directions and start: one register stage, reordered to {U,D,R,L}.
  always_ff @(posedge clk) begin
    if (reset) begin
      joy_1   <= 4'd0;
      joy_2   <= 4'd0;
      start_1 <= 1'b0;
      start_2 <= 1'b0;
    end else begin
      joy_1   <= {raw[0][3], raw[0][2], raw[0][0], raw[0][1]};
      joy_2   <= {raw[1][3], raw[1][2], raw[1][0], raw[1][1]};
      start_1 <= raw[0][SB];
      start_2 <= raw[1][SB];
    end
  end

  // Autofire state per player per button.
  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      for (int b = 0; b < NUM_BUTTONS; b++) begin
        if (reset) af_r[p][b] <= '0;
        else       af_r[p][b] <= af_next(raw[p][FB+b], autofire_en[b], af_r[p][b]);
      end
    end
  end

  // Expose the registered autofire outputs.
  always_comb begin
    buttons_1 = '0;
    buttons_2 = '0;
    for (int b = 0; b < NUM_BUTTONS; b++) begin
      buttons_1[b] = af_r[0][b].btn;
      buttons_2[b] = af_r[1][b].btn;
    end
  end

  // Coin stretcher next state: one fixed-length pulse per physical press.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      coin_st_nxt[p]  = coin_st_r[p];
      coin_cnt_nxt[p] = coin_cnt_r[p];
      coin_out_nxt[p] = 1'b0;
      case (coin_st_r[p])
        C_IDLE: begin
          if (raw[p][KB] && !coin_prev_r[p]) begin
            coin_st_nxt[p]  = C_PULSE;
            coin_cnt_nxt[p] = '0;
            coin_out_nxt[p] = 1'b1;
          end else begin
            coin_st_nxt[p]  = C_IDLE;
          end
        end
        C_PULSE: begin
          if (coin_cnt_r[p] == PW'(COIN_PULSE - 1)) begin
            coin_st_nxt[p]  = raw[p][KB] ? C_WAIT : C_IDLE;
            coin_cnt_nxt[p] = '0;
          end else begin
            coin_cnt_nxt[p] = coin_cnt_r[p] + PW'(1);
            coin_out_nxt[p] = 1'b1;
          end
        end
        C_WAIT: begin
          if (!raw[p][KB]) coin_st_nxt[p] = C_IDLE;
          else             coin_st_nxt[p] = C_WAIT;
        end
        default: begin
          coin_st_nxt[p]  = C_IDLE;
          coin_cnt_nxt[p] = '0;
        end
      endcase
    end
  end

  // Coin stretcher state registers and registered coin outputs.
  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (reset) begin
        coin_st_r[p]   <= C_IDLE;
        coin_cnt_r[p]  <= '0;
        coin_prev_r[p] <= 1'b0;
        coin_out_r[p]  <= 1'b0;
      end else begin
        coin_st_r[p]   <= coin_st_nxt[p];
        coin_cnt_r[p]  <= coin_cnt_nxt[p];
        coin_prev_r[p] <= raw[p][KB];
        coin_out_r[p]  <= coin_out_nxt[p];
      end
    end
  end

  assign coin_1 = coin_out_r[0];
  assign coin_2 = coin_out_r[1];

endmodule

// File: tb/tb_arcade_input.sv
// Scoreboard bench for arcade_input: the stimulus process queues the expected
// output word for a given cycle, the monitor compares on each falling edge.
module tb_arcade_input;
  localparam int NB = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [10:0]   ps2_key;
  logic [7:0]    joystick_0, joystick_1;
  logic          share;
  logic [NB-1:0] autofire_en;
  logic [3:0]    joy_1, joy_2;
  logic [NB-1:0] buttons_1, buttons_2;
  logic          start_1, start_2, coin_1, coin_2;

  arcade_input #(.NUM_BUTTONS(NB), .AUTOFIRE_HALF(4), .COIN_PULSE(10)) dut (
    .clk(clk), .reset(reset), .ps2_key(ps2_key),
    .joystick_0(joystick_0), .joystick_1(joystick_1),
    .share(share), .autofire_en(autofire_en),
    .joy_1(joy_1), .joy_2(joy_2), .buttons_1(buttons_1), .buttons_2(buttons_2),
    .start_1(start_1), .start_2(start_2), .coin_1(coin_1), .coin_2(coin_2)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [15:0] val;
    string       name;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  logic        tog = 1'b0;
  logic [15:0] outv;

  assign outv = {joy_1, joy_2, buttons_1, buttons_2, start_1, start_2, coin_1, coin_2};

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation that is due at this falling edge.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      cur = sb.pop_front();
      vectors++;
      if (outv !== cur.val) begin
        miscompares++;
        $display("FAIL %s @cyc %0d: got %h, want %h", cur.name, cyc, outv, cur.val);
      end
    end
  end

  function automatic logic [15:0] ov(input logic [3:0] j1, input logic [3:0] j2,
                                     input logic [1:0] b1, input logic [1:0] b2,
                                     input logic s1, input logic s2,
                                     input logic c1, input logic c2);
    return {j1, j2, b1, b2, s1, s2, c1, c2};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue the output expected after the next rising edge, then advance.
  task automatic cexp(input logic [15:0] v, input string nm);
    exp_t n;
    n.cyc  = cyc + 1;
    n.val  = v;
    n.name = nm;
    sb.push_back(n);
    tick();
  endtask

  task automatic ps2_ev(input logic [7:0] code, input logic pressed);
    tog     = ~tog;
    ps2_key = {tog, pressed, 1'b0, code};
  endtask

  logic [19:0] af_pat;
  logic [13:0] coin_pat;
  logic [15:0] z;

  initial begin
    af_pat   = 20'b1111_0000_1111_0000_1111;
    coin_pat = 14'b11100111111100;
    z        = 16'h0000;
    reset = 1'b1; ps2_key = 11'd0; joystick_0 = 8'd0; joystick_1 = 8'd0;
    share = 1'b0; autofire_en = 2'b00;

    repeat (3) cexp(z, "reset");
    reset = 1'b0;
    cexp(z, "idle");

    // P1 up via PS/2: two-cycle latency for press and release.
    ps2_ev(8'h75, 1'b1);
    cexp(z, "ps2 up lat1");
    cexp(ov(4'b1000, 4'b0, 2'b0, 2'b0, 1'b0, 1'b0, 1'b0, 1'b0), "ps2 up");
    cexp(ov(4'b1000, 4'b0, 2'b0, 2'b0, 1'b0, 1'b0, 1'b0, 1'b0), "ps2 up hold");
    ps2_ev(8'h75, 1'b0);
    cexp(ov(4'b1000, 4'b0, 2'b0, 2'b0, 1'b0, 1'b0, 1'b0, 1'b0), "ps2 rel lat1");
    cexp(z, "ps2 rel");

    // Joystick 1 right, separate then shared.
    joystick_1 = 8'h01;
    cexp(ov(4'b0, 4'b0010, 2'b0, 2'b0, 1'b0, 1'b0, 1'b0, 1'b0), "joy2 right");
    share = 1'b1;
    cexp(ov(4'b0010, 4'b0010, 2'b0, 2'b0, 1'b0, 1'b0, 1'b0, 1'b0), "share right");
    share = 1'b0; joystick_1 = 8'h00;
    cexp(z, "joy clear");

    // P2 fire0 key, then shared onto P1.
    ps2_ev(8'h1C, 1'b1);
    cexp(z, "p2 fire lat1");
    cexp(ov(4'b0, 4'b0, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0), "p2 fire");
    share = 1'b1;
    cexp(ov(4'b0, 4'b0, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0), "share fire");
    ps2_ev(8'h1C, 1'b0);
    cexp(ov(4'b0, 4'b0, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0), "p2 rel lat1");
    cexp(z, "p2 rel");
    share = 1'b0;

    // P2 left key.
    ps2_ev(8'h23, 1'b1);
    cexp(z, "p2 left lat1");
    cexp(ov(4'b0, 4'b0001, 2'b0, 2'b0, 1'b0, 1'b0, 1'b0, 1'b0), "p2 left");
    ps2_ev(8'h23, 1'b0);
    cexp(ov(4'b0, 4'b0001, 2'b0, 2'b0, 1'b0, 1'b0, 1'b0, 1'b0), "p2 left rel lat1");
    cexp(z, "p2 left rel");

    // Autofire on fire0, plain fire1, both held 20 cycles.
    autofire_en = 2'b01;
    joystick_0  = 8'h30;
    for (int i = 0; i < 20; i++)
      cexp(ov(4'b0, 4'b0, {1'b1, af_pat[19-i]}, 2'b0, 1'b0, 1'b0, 1'b0, 1'b0), "autofire");
    joystick_0 = 8'h00;
    cexp(z, "autofire release");

    // Start.
    joystick_0 = 8'h40;
    cexp(ov(4'b0, 4'b0, 2'b0, 2'b0, 1'b1, 1'b0, 1'b0, 1'b0), "start1");
    joystick_0 = 8'h00;
    cexp(z, "start1 release");

    // Coin held 30 cycles: a single 10-cycle pulse.
    for (int i = 0; i < 30; i++) begin
      joystick_0 = 8'h80;
      cexp(ov(4'b0, 4'b0, 2'b0, 2'b0, 1'b0, 1'b0, (i < 10), 1'b0), "coin hold");
    end
    joystick_0 = 8'h00;
    cexp(z, "coin release");
    cexp(z, "coin idle");

    // Second press with a re-press inside the pulse: no extension.
    for (int i = 0; i < 14; i++) begin
      joystick_0 = coin_pat[13-i] ? 8'h80 : 8'h00;
      cexp(ov(4'b0, 4'b0, 2'b0, 2'b0, 1'b0, 1'b0, (i < 10), 1'b0), "coin no-extend");
    end

    // Reset during a coin pulse and autofire, with a toggle flip under reset.
    ps2_ev(8'h75, 1'b1);
    joystick_0 = 8'h90;
    cexp(ov(4'b0, 4'b0, 2'b01, 2'b0, 1'b0, 1'b0, 1'b1, 1'b0), "pre-reset a");
    cexp(ov(4'b1000, 4'b0, 2'b01, 2'b0, 1'b0, 1'b0, 1'b1, 1'b0), "pre-reset b");
    reset = 1'b1;
    joystick_0 = 8'h00;
    ps2_ev(8'h75, 1'b1);
    cexp(z, "reset mid-op");
    reset = 1'b0;
    cexp(z, "post reset");
    cexp(z, "no spurious ev 1");
    cexp(z, "no spurious ev 2");

    // fire2 key with two buttons, and an unmapped code.
    ps2_ev(8'h29, 1'b1);
    cexp(z, "fire2 ignored 1");
    cexp(z, "fire2 ignored 2");
    ps2_ev(8'h5A, 1'b1);
    cexp(z, "unmapped 1");
    cexp(z, "unmapped 2");

    for (int k = 0; k < 20 && sb.size() > 0; k++) tick();
    if (sb.size() > 0) begin
      miscompares += sb.size();
      $display("FAIL drain: %0d expectations pending, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
